bin2bcd_arb_ctrl: RTL

Shares a single serial double-dabble binary-to-BCD engine between several requesters. A round-robin arbiter selects one pending request and captures its binary operand. An FSM then sequences the shift/add-3 iterations and returns the BCD result with a one-cycle done/ack handshake. The block sits between the binary-producing blocks and the decimal display/output logic.

---
 rtl/bin2bcd_arb_ctrl_if.sv | 29 ++
 rtl/bin2bcd_arb_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_arb_ctrl_if.sv
// bin2bcd_arb_ctrl_if: requester/result bundle for the shared BCD engine.
// master = requester side (req, binaryNumbers), slave = converter side.
interface bin2bcd_arb_ctrl_if #(
  parameter int binaryNumberWidth = 16,
  parameter int busWidth          = 4,
  parameter int numberOfDigits    = 5,
  parameter int numRequesters     = 4
);
  localparam int IDW = $clog2(numRequesters);

  logic [numRequesters-1:0] req;
  logic [numRequesters-1:0][binaryNumberWidth-1:0] binaryNumbers;
  logic [numRequesters-1:0] ack;
  logic busy;
  logic done;
  logic [IDW-1:0] doneId;
  logic [numberOfDigits-1:0][busWidth-1:0] BinaryDecimal;
  logic overflow;

  modport master (
    output req, binaryNumbers,
    input  ack, busy, done, doneId, BinaryDecimal, overflow
  );

  modport slave (
    input  req, binaryNumbers,
    output ack, busy, done, doneId, BinaryDecimal, overflow
  );
endinterface

// File: rtl/bin2bcd_arb_ctrl.sv
// bin2bcd_arb_ctrl: round-robin shared serial double-dabble converter.
// Ports: clk, rst (async high), bus (slave: req/binaryNumbers in;
// ack/busy/done/doneId/BinaryDecimal/overflow out).
// Option macro BCD_LZ_BLANK_EN: leading zero digits read as 4'hF.
module bin2bcd_arb_ctrl #(
  parameter int binaryNumberWidth = 16,
  parameter int busWidth          = 4,
  parameter int numberOfDigits    = 5,
  parameter int numRequesters     = 4
) (
  input logic clk,
  input logic rst,
  bin2bcd_arb_ctrl_if.slave bus
);
  localparam int W   = binaryNumberWidth;
  localparam int N   = numRequesters;
  localparam int D   = numberOfDigits;
  localparam int IDW = $clog2(N);
  localparam int CW  = $clog2(W + 1);
  localparam int AW  = D * 4;

  if (busWidth != 4) begin : gBadBus
    $error("bin2bcd_arb_ctrl: busWidth must be 4");
  end
  if (N < 2 || W < 2 || D < 1) begin : gBadCfg
    $error("bin2bcd_arb_ctrl: bad W/N/D");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, stateNxt;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grantId;
  logic [IDW-1:0] gnt;
  logic anyReq;
  logic [W-1:0] binReg;
  logic [AW-1:0] bcdReg;
  logic [AW-1:0] adj;
  logic [AW-1:0] result;
  logic ovfReg;
  logic [CW-1:0] cnt;

  // First requester at or above ptr, wrapping.
  always_comb begin
    int idx;
    idx = 0;
    anyReq = 1'b0;
    gnt = '0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!anyReq && bus.req[idx]) begin
        anyReq = 1'b1;
        gnt = IDW'(idx);
      end
    end
  end

  // Add-3 correction ahead of each shift.
  always_comb begin
    adj = bcdReg;
    for (int i = 0; i < D; i++) begin
      if (bcdReg[i*4 +: 4] > 4'd4) begin
        adj[i*4 +: 4] = bcdReg[i*4 +: 4] + 4'd3;
      end
    end
  end

`ifdef BCD_LZ_BLANK_EN
  always_comb begin
    logic seen;
    seen = 1'b0;
    result = bcdReg;
    for (int i = D - 1; i >= 1; i--) begin
      if (bcdReg[i*4 +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen) begin
        result[i*4 +: 4] = 4'hF;
      end
    end
  end
`else
  assign result = bcdReg;
`endif

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (anyReq) stateNxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) stateNxt = DONE;
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr     <= '0;
      grantId <= '0;
      binReg  <= '0;
      bcdReg  <= '0;
      ovfReg  <= 1'b0;
      cnt     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (anyReq) begin
            binReg  <= bus.binaryNumbers[gnt];
            bcdReg  <= '0;
            ovfReg  <= 1'b0;
            cnt     <= CW'(W);
            grantId <= gnt;
            ptr     <= (gnt == IDW'(N - 1)) ? '0 : gnt + 1'b1;
          end
        end
        SHIFT: begin
          bcdReg <= {adj[AW-2:0], binReg[W-1]};
          binReg <= {binReg[W-2:0], 1'b0};
          ovfReg <= ovfReg | adj[AW-1];
          cnt    <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result side: registered off the DONE state, held until next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.done          <= 1'b0;
      bus.ack           <= '0;
      bus.doneId        <= '0;
      bus.BinaryDecimal <= '0;
      bus.overflow      <= 1'b0;
    end else begin
      bus.done <= (state == DONE);
      bus.ack  <= '0;
      if (state == DONE) begin
        bus.ack           <= {{(N-1){1'b0}}, 1'b1} << grantId;
        bus.doneId        <= grantId;
        bus.BinaryDecimal <= result;
        bus.overflow      <= ovfReg;
      end
    end
  end

  assign bus.busy = (state != IDLE);
endmodule
